// File: rtl/systolic_mm_engine_if.sv
// Stream/handshake bundle for systolic_mm_engine: operand streams in, C stream and status out.
interface systolic_mm_engine_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
);
  logic             en;
  logic             acc_mode;
  logic [DW-1:0]    shift_in_A;
  logic [DW-1:0]    shift_in_B;
  logic [ACC_W-1:0] shift_out;
  logic             out_valid;
  logic             busy;
  logic             ack;

  modport master (
    output en, acc_mode, shift_in_A, shift_in_B,
    input  shift_out, out_valid, busy, ack
  );

  modport slave (
    input  en, acc_mode, shift_in_A, shift_in_B,
    output shift_out, out_valid, busy, ack
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic matrix multiplier: loads A and B row-major,
// skews them through the PE grid, then streams C out row-major.
module systolic_mm_engine #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 2*DW + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst,
  systolic_mm_engine_if.slave bus
);
  localparam int NN = N * N;
  localparam int CW = $clog2(NN);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_acc_mode;
  logic             r_busy;
  logic             r_ack;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_shift_out;

  logic [DW-1:0]    r_amat [NN];
  logic [DW-1:0]    r_bmat [NN];
  logic [ACC_W-1:0] r_acc  [NN];
  logic [DW-1:0]    r_pa   [N][N-1];
  logic [DW-1:0]    r_pb   [N-1][N];

  logic [DW-1:0]    w_inj_a [N];
  logic [DW-1:0]    w_inj_b [N];
  logic             w_mac;
  logic             w_clr;

  assign w_mac = (r_state == COMPUTE);
  assign w_clr = (r_state == LOAD) && (r_cnt == '0) && !r_acc_mode;

  assign bus.shift_out = r_shift_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.ack       = r_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc_mode  <= 1'b0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_out_valid <= 1'b0;
      r_shift_out <= '0;
      for (int k = 0; k < NN; k++) begin
        r_amat[k] <= '0;
        r_bmat[k] <= '0;
      end
    end else begin
      r_ack       <= 1'b0;
      r_out_valid <= 1'b0;
      r_shift_out <= '0;
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state    <= LOAD;
            r_cnt      <= '0;
            r_acc_mode <= bus.acc_mode;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          r_amat[r_cnt] <= bus.shift_in_A;
          r_bmat[r_cnt] <= bus.shift_in_B;
          if (r_cnt == CW'(NN - 1)) begin
            r_state <= COMPUTE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        COMPUTE: begin
          // PE(0,0) finished long ago, so C[0] is safe to present on DRAIN entry.
          if (r_cnt == CW'(3*N - 3)) begin
            r_state     <= DRAIN;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_shift_out <= r_acc[0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (r_cnt == CW'(NN - 1)) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + CW'(1);
            r_out_valid <= 1'b1;
            r_shift_out <= r_acc[r_cnt + CW'(1)];
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Edge injection: row/column gi sees element k = step - gi, zero outside 0..N-1.
  for (genvar gi = 0; gi < N; gi++) begin : g_inj
    logic [CW-1:0] w_k;
    logic [CW-1:0] w_ia;
    logic [CW-1:0] w_ib;
    logic          w_live;

    assign w_k    = r_cnt - CW'(gi);
    assign w_live = w_mac && (w_k < CW'(N));
    assign w_ia   = CW'(gi * N) + w_k;
    assign w_ib   = w_k * CW'(N) + CW'(gi);

    assign w_inj_a[gi] = w_live ? r_amat[w_ia] : '0;
    assign w_inj_b[gi] = w_live ? r_bmat[w_ib] : '0;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int IDX = gi * N + gj;
      logic [DW-1:0]    w_a;
      logic [DW-1:0]    w_b;
      logic [ACC_W-1:0] w_ax;
      logic [ACC_W-1:0] w_bx;

      if (gj == 0) begin : g_a_edge
        assign w_a = w_inj_a[gi];
      end else begin : g_a_pipe
        assign w_a = r_pa[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign w_b = w_inj_b[gj];
      end else begin : g_b_pipe
        assign w_b = r_pb[gi-1][gj];
      end

      // Extending operands before the multiply gives the exact product modulo 2^ACC_W.
      assign w_ax = {{(ACC_W-DW){(SIGNED != 0) && w_a[DW-1]}}, w_a};
      assign w_bx = {{(ACC_W-DW){(SIGNED != 0) && w_b[DW-1]}}, w_b};

      always_ff @(posedge clk) begin
        if (rst || w_clr) begin
          r_acc[IDX] <= '0;
        end else if (w_mac) begin
          r_acc[IDX] <= r_acc[IDX] + w_ax * w_bx;
        end
      end

      if (gj < N - 1) begin : g_pa
        always_ff @(posedge clk) begin
          if (rst) r_pa[gi][gj] <= '0;
          else     r_pa[gi][gj] <= w_mac ? w_a : '0;
        end
      end
      if (gi < N - 1) begin : g_pb
        always_ff @(posedge clk) begin
          if (rst) r_pb[gi][gj] <= '0;
          else     r_pb[gi][gj] <= w_mac ? w_b : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Randomised bench for systolic_mm_engine: three instances (N=2 unsigned, N=2 signed, N=4 unsigned)
// checked cycle by cycle against a plain matrix-multiply model.
module tb_systolic_mm_engine;
  localparam int DW    = 8;
  localparam int AW_N2 = 2*DW + 1;
  localparam int AW_N4 = 2*DW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int            sel;
  logic          en_v;
  logic          acc_v;
  logic [DW-1:0] a_v;
  logic [DW-1:0] b_v;

  systolic_mm_engine_if #(.DW(DW), .ACC_W(AW_N2)) bus_u2 ();
  systolic_mm_engine_if #(.DW(DW), .ACC_W(AW_N2)) bus_s2 ();
  systolic_mm_engine_if #(.DW(DW), .ACC_W(AW_N4)) bus_u4 ();

  assign bus_u2.en = en_v && (sel == 0);
  assign bus_s2.en = en_v && (sel == 1);
  assign bus_u4.en = en_v && (sel == 2);
  assign bus_u2.acc_mode = acc_v;
  assign bus_s2.acc_mode = acc_v;
  assign bus_u4.acc_mode = acc_v;
  assign bus_u2.shift_in_A = a_v;
  assign bus_s2.shift_in_A = a_v;
  assign bus_u4.shift_in_A = a_v;
  assign bus_u2.shift_in_B = b_v;
  assign bus_s2.shift_in_B = b_v;
  assign bus_u4.shift_in_B = b_v;

  systolic_mm_engine #(.N(2), .DW(DW), .ACC_W(AW_N2), .SIGNED(0)) dut_u2 (.clk(clk), .rst(rst), .bus(bus_u2));
  systolic_mm_engine #(.N(2), .DW(DW), .ACC_W(AW_N2), .SIGNED(1)) dut_s2 (.clk(clk), .rst(rst), .bus(bus_s2));
  systolic_mm_engine #(.N(4), .DW(DW), .ACC_W(AW_N4), .SIGNED(0)) dut_u4 (.clk(clk), .rst(rst), .bus(bus_u4));

  logic        o_valid, o_busy, o_ack;
  logic [31:0] o_data;
  always_comb begin
    case (sel)
      0: begin
        o_valid = bus_u2.out_valid; o_busy = bus_u2.busy; o_ack = bus_u2.ack;
        o_data  = 32'(bus_u2.shift_out);
      end
      1: begin
        o_valid = bus_s2.out_valid; o_busy = bus_s2.busy; o_ack = bus_s2.ack;
        o_data  = 32'(bus_s2.shift_out);
      end
      default: begin
        o_valid = bus_u4.out_valid; o_busy = bus_u4.busy; o_ack = bus_u4.ack;
        o_data  = 32'(bus_u4.shift_out);
      end
    endcase
  end

  int            n_vec = 0;
  int            n_err = 0;
  int            run_id = 0;
  longint        acc_m [3][64];
  logic [DW-1:0] mat_a [64];
  logic [DW-1:0] mat_b [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (run %0d, t=%0t): got %0d expected %0d", tag, run_id, $time, got, exp);
    end
  endtask

  function automatic int dim(input int s);
    return (s == 2) ? 4 : 2;
  endfunction

  function automatic int accw(input int s);
    return (s == 2) ? AW_N4 : AW_N2;
  endfunction

  function automatic longint opv(input logic [DW-1:0] x, input bit sg);
    if (sg) return longint'($signed(x));
    return longint'({56'b0, x});
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 64; k++) acc_m[s][k] = 0;
  endtask

  // One complete operation; en is sampled at cycle 0, outputs are checked every cycle.
  task automatic run_mm(input int s, input bit am, input bit noise, input int rst_at);
    int     n, d_cyc, first;
    bit     sg, exp_v;
    longint mask, sum;
    longint c_exp [64];
    n     = dim(s);
    sg    = (s == 1);
    d_cyc = 2*n*n + 3*n - 1;
    first = n*n + 3*n - 1;
    mask  = (longint'(1) << accw(s)) - 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        sum = am ? acc_m[s][i*n+j] : 0;
        for (int k = 0; k < n; k++) sum += opv(mat_a[i*n+k], sg) * opv(mat_b[k*n+j], sg);
        c_exp[i*n+j] = sum & mask;
      end
    sel = s;
    run_id++;
    for (int c = 0; c <= d_cyc; c++) begin
      @(negedge clk);
      exp_v = (c >= first) && (c < d_cyc);
      chk("busy", 32'(o_busy), (c >= 1) ? 1 : 0);
      chk("out_valid", 32'(o_valid), 32'(exp_v));
      chk("shift_out", o_data, exp_v ? 32'(c_exp[c-first]) : 0);
      chk("ack", 32'(o_ack), (c == d_cyc) ? 1 : 0);
      en_v  = (c == 0) || (noise && c < d_cyc && $urandom_range(0, 1) == 1);
      acc_v = (c == 0) ? am : 1'($urandom);
      a_v   = (c >= 1 && c <= n*n) ? mat_a[c-1] : DW'($urandom);
      b_v   = (c >= 1 && c <= n*n) ? mat_b[c-1] : DW'($urandom);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ack", 32'(o_ack), 0);
        chk("rst_data", o_data, 0);
        rst  = 1'b0;
        en_v = 1'b0;
        clear_model();
        $display("run %0d: inst=%0d N=%0d acc_mode=%0d noise=%0d aborted by reset at cycle %0d",
                 run_id, s, n, am, noise, rst_at);
        return;
      end
    end
    en_v = 1'b0;
    for (int k = 0; k < n*n; k++) acc_m[s][k] = c_exp[k];
    $display("run %0d: inst=%0d N=%0d acc_mode=%0d noise=%0d C[0]=%0d C[last]=%0d",
             run_id, s, n, am, noise, c_exp[0], c_exp[n*n-1]);
  endtask

  task automatic set_n2(input int a0, input int a1, input int a2, input int a3);
    mat_a[0] = DW'(a0); mat_a[1] = DW'(a1); mat_a[2] = DW'(a2); mat_a[3] = DW'(a3);
    mat_b[0] = 8'd5;    mat_b[1] = 8'd6;    mat_b[2] = 8'd7;    mat_b[3] = 8'd8;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n, dcy, ra;
    sel = 0; en_v = 1'b0; acc_v = 1'b0; a_v = '0; b_v = '0;
    clear_model();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("reset_busy", 32'(o_busy), 0);
      chk("reset_valid", 32'(o_valid), 0);
      chk("reset_ack", 32'(o_ack), 0);
      chk("reset_data", o_data, 0);
    end
    rst = 1'b0;

    // Worked examples: plain, K-tiled accumulate, en noise, reset abort, signed, full-scale.
    set_n2(1, 2, 3, 4);
    run_mm(0, 1'b0, 1'b0, -1);
    run_mm(0, 1'b1, 1'b0, -1);
    run_mm(0, 1'b0, 1'b1, -1);
    run_mm(0, 1'b0, 1'b0, 6);
    run_mm(0, 1'b1, 1'b0, -1);
    set_n2(-1, -2, 3, 4);
    run_mm(1, 1'b0, 1'b0, -1);
    for (int k = 0; k < 16; k++) begin mat_a[k] = 8'hFF; mat_b[k] = 8'hFF; end
    run_mm(2, 1'b0, 1'b0, -1);
    run_mm(2, 1'b1, 1'b1, -1);

    for (int r = 0; r < 24; r++) begin
      s   = r % 3;
      n   = dim(s);
      dcy = 2*n*n + 3*n - 1;
      for (int k = 0; k < n*n; k++) begin
        mat_a[k] = DW'($urandom);
        mat_b[k] = DW'($urandom);
      end
      ra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, dcy - 1)) : -1;
      run_mm(s, 1'($urandom), 1'($urandom), ra);
    end

    @(negedge clk);
    chk("final_busy", 32'(o_busy), 0);
    chk("final_ack", 32'(o_ack), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/systolic_mm_engine.md
SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (N x N PEs); legal range 2..8.
REQ-002 SHALL have parameter DW, default 8, meaning operand width.
REQ-003 SHALL have parameter ACC_W, default 2*DW+$clog2(N), meaning accumulator and result width.
REQ-004 SHALL have parameter SIGNED, default 0, meaning 0 = unsigned operands, 1 = two's-complement operands.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port en, input, 1, start request.
REQ-008 SHALL have port acc_mode, input, 1, sampled with en: 1 = keep prior accumulators (K-tiling), 0 = clear.
REQ-009 SHALL have port shift_in_A, input, DW, A element stream.
REQ-010 SHALL have port shift_in_B, input, DW, B element stream.
REQ-011 SHALL have port shift_out, output, ACC_W, C element stream.
REQ-012 SHALL have port out_valid, output, 1, shift_out holds a valid C element.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port ack, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, COMPUTE, DRAIN, DONE.
REQ-016 SHALL transition IDLE->LOAD on the cycle after en=1 is sampled in IDLE; acc_mode SHALL be latched on that same cycle.
REQ-017 SHALL ignore en in all states other than IDLE.
REQ-018 SHALL, in LOAD, capture exactly N*N element pairs on consecutive cycles; at load index k: A[k/N][k%N] and B[k/N][k%N] (both row-major).
REQ-019 SHALL, when the latched acc_mode=0, clear all N*N accumulators on the first LOAD cycle; when acc_mode=1, SHALL retain them.
REQ-020 SHALL use an output-stationary dataflow in COMPUTE:
- row i of A is injected i cycles late;
- column j of B is injected j cycles late;
- operands pass right (A) and down (B) through one register per PE;
- zeros are injected outside valid slots.
REQ-021 SHALL hold COMPUTE for exactly 3N-2 cycles, then enter DRAIN.
REQ-022 SHALL compute each PE as acc += a*b, with the product sign- or zero-extended per SIGNED to ACC_W, and the sum wrapping modulo 2^ACC_W.
REQ-023 SHALL, in DRAIN, output C row-major, one element per cycle for N*N cycles, with out_valid=1 on each of those cycles.
REQ-024 SHALL hold shift_out=0 and out_valid=0 outside DRAIN.
REQ-025 SHALL, after the last DRAIN element, enter DONE for one cycle with ack=1, then return to IDLE.
REQ-026 SHALL meet this timing, with en sampled at cycle 0:
- LOAD on cycles 1..N²;
- COMPUTE on cycles N²+1..N²+3N-2;
- DRAIN on cycles N²+3N-1..2N²+3N-2;
- ack on cycle 2N²+3N-1.
REQ-027 SHALL accept en=1 sampled in IDLE on the cycle immediately after DONE (back-to-back operation).
REQ-028 SHALL leave accumulator contents unchanged after DRAIN, so that a following acc_mode=1 run accumulates onto them.

Reset
REQ-029 SHALL, when rst=1, on the next rising edge force:
- state to IDLE;
- all accumulators, operand pipelines and counters to 0;
- shift_out=0, out_valid=0, busy=0, ack=0.
REQ-030 SHALL give rst priority over en and over any in-progress operation (reset mid-LOAD/COMPUTE/DRAIN aborts the operation with no ack).

Verification
REQ-031 SHALL pass this scenario: N=2, SIGNED=0, acc_mode=0; A rows [1,2],[3,4]; B rows [5,6],[7,8] -> out_valid on cycles 9..12 with shift_out 19,22,43,50, ack on cycle 13.
REQ-032 SHALL pass this scenario: the REQ-031 run followed immediately by a second run with the same data and acc_mode=1 -> output 38,44,86,100.
REQ-033 SHALL pass this scenario: N=2, SIGNED=1; A rows [-1,-2],[3,4]; B as in REQ-031 -> output -19,-22,43,50 as ACC_W-bit two's complement.
REQ-034 SHALL pass this scenario: N=4, DW=8, SIGNED=0, all A and B elements 255 -> all 16 outputs 260100, no wrap; ack on cycle 43.
REQ-035 SHALL pass this scenario: rst=1 on cycle 6 of a REQ-031 run -> busy=0 and out_valid=0 from the next cycle, no ack; a fresh run with acc_mode=1 then outputs exactly the REQ-031 results.
REQ-036 SHALL pass this scenario: en pulsed during LOAD, COMPUTE and DRAIN -> timing and results identical to REQ-031, and exactly one ack.
